writeback_arbiter: RTL

- Sits between the execution units and the register file write port. It is the producer side of the port that carries `wrt_high_enable`, `destn_reg` and `destn_data`.
- Accepts results from the ALU and the LSU over valid/ready handshakes and buffers them in a small FIFO.
- Drains the FIFO at one register write per cycle, and exposes a pending-destination mask for hazard detection in decode.

---
 rtl/writeback_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin accept of ALU/LSU results into a small FIFO,
// drained one register-file write per cycle, with a pending-destination mask.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 64,
    parameter int REG_W      = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_W-1:0]              alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [REG_W-1:0]              lsu_rd,
    input  logic [DATA_W-1:0]             lsu_data,
    input  logic                          wb_hold,
    output logic                          wrt_high_enable,
    output logic [REG_W-1:0]              destn_reg,
    output logic [DATA_W-1:0]             destn_data,
    output logic [31:0]                   pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Handshake: a source transfers on a cycle where its valid and ready are
    // both high; ready may look at valid, valid never looks at ready.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [REG_W-1:0]  entry_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] entry_data [FIFO_DEPTH];

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              rr_alu;
    logic              empty;
    logic              pop;
    logic              space;
    logic              alu_fire;
    logic              lsu_fire;
    logic              grant;
    logic              push;
    logic [REG_W-1:0]  push_rd;
    logic [DATA_W-1:0] push_data;
    logic [PW-1:0]     slot;

    assign empty           = (fifo_count == '0);
    assign pop             = !empty && !wb_hold;
    assign wrt_high_enable = pop;
    assign destn_reg       = empty ? '0 : entry_rd[rd_ptr];
    assign destn_data      = empty ? '0 : entry_data[rd_ptr];

    // A pop frees the head slot at the same edge, so a full FIFO can still accept.
    assign space     = (fifo_count != DEPTH_C) || pop;
    assign alu_ready = !reset && space && (!lsu_valid || rr_alu);
    assign lsu_ready = !reset && space && (!alu_valid || !rr_alu);
    assign alu_fire  = alu_valid && alu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign grant     = alu_fire || lsu_fire;
    assign push_rd   = alu_fire ? alu_rd : lsu_rd;
    assign push_data = alu_fire ? alu_data : lsu_data;
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push      = grant && (push_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            rr_alu     <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (grant)
                rr_alu <= lsu_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_rd[wr_ptr]   <= push_rd;
            entry_data[wr_ptr] <= push_data;
        end
    end

    // Only the fifo_count slots starting at the head hold live entries.
    always_comb begin
        pending_mask = '0;
        slot         = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (CW'(i) < fifo_count)
                pending_mask[entry_rd[slot]] = 1'b1;
        end
    end

endmodule
